// File: rtl/rate_seq_pkg.sv
// Shared types for the divider rate sequencer.
// State encoding, default widths and the slot record.
package rate_seq_pkg;

  localparam int RS_NUM_SLOTS = 4;
  localparam int RS_DIV_W     = 32;
  localparam int RS_REP_W     = 8;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN
  } state_e;

  typedef struct packed {
    logic [RS_DIV_W-1:0] divide;
    logic [RS_REP_W-1:0] rpt;
  } slot_t;

endpackage

// File: rtl/rate_table.sv
// Slot table: (divide, repeat) per entry.
// Synchronous write and clear, combinational read.
module rate_table #(
  parameter int NUM_SLOTS = 4,
  parameter int DIV_W     = 32,
  parameter int REP_W     = 8,
  parameter int SLOT_W    = $clog2(NUM_SLOTS)
) (
  input  logic              clock_in,
  input  logic              reset,
  input  logic              cfg_we,
  input  logic [SLOT_W-1:0] cfg_addr,
  input  logic [DIV_W-1:0]  cfg_divide,
  input  logic [REP_W-1:0]  cfg_repeat,
  input  logic [SLOT_W-1:0] rd_addr,
  output logic [DIV_W-1:0]  rd_divide,
  output logic [REP_W-1:0]  rd_repeat
);

  logic [DIV_W-1:0] div_mem [NUM_SLOTS];
  logic [REP_W-1:0] rep_mem [NUM_SLOTS];

  // Clear on reset, otherwise accept config writes in any state.
  always_ff @(posedge clock_in) begin
    if (reset) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        div_mem[i] <= '0;
        rep_mem[i] <= '0;
      end
    end else if (cfg_we) begin
      div_mem[cfg_addr] <= cfg_divide;
      rep_mem[cfg_addr] <= cfg_repeat;
    end
  end

  assign rd_divide = div_mem[rd_addr];
  assign rd_repeat = rep_mem[rd_addr];

endmodule

// File: rtl/rate_sequencer.sv
// Steps the clock divider through a table of rates,
// counting divider rising edges per slot.
module rate_sequencer
  import rate_seq_pkg::*;
#(
  parameter int NUM_SLOTS = RS_NUM_SLOTS,
  parameter int DIV_W     = RS_DIV_W,
  parameter int REP_W     = RS_REP_W,
  parameter int SLOT_W    = $clog2(NUM_SLOTS)
) (
  input  logic              clock_in,
  input  logic              reset,
  input  logic              cfg_we,
  input  logic [SLOT_W-1:0] cfg_addr,
  input  logic [DIV_W-1:0]  cfg_divide,
  input  logic [REP_W-1:0]  cfg_repeat,
  input  logic              start,
  input  logic              stop,
  input  logic              loop,
  input  logic              div_clock,
  output logic [DIV_W-1:0]  divide_by,
  output logic              div_reset_n,
  output logic              busy,
  output logic [SLOT_W-1:0] slot,
  output logic              done
);

  localparam logic [SLOT_W-1:0] LAST_SLOT =
    SLOT_W'(NUM_SLOTS - 1);

  state_e           state;
  logic [REP_W-1:0] rep_cnt;
  logic [REP_W-1:0] rep_lim;
  logic             div_clock_q;
  logic             rise;
  logic [DIV_W-1:0] tbl_divide;
  logic [REP_W-1:0] tbl_repeat;
  logic [REP_W-1:0] tbl_last;

  rate_table #(
    .NUM_SLOTS (NUM_SLOTS),
    .DIV_W     (DIV_W),
    .REP_W     (REP_W),
    .SLOT_W    (SLOT_W)
  ) u_table (
    .clock_in   (clock_in),
    .reset      (reset),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_divide (cfg_divide),
    .cfg_repeat (cfg_repeat),
    .rd_addr    (slot),
    .rd_divide  (tbl_divide),
    .rd_repeat  (tbl_repeat)
  );

  assign rise = div_clock & ~div_clock_q;

  // Repeat 0 behaves as 1; latched at LOAD so
  // a mid-run write cannot change the count.
  assign tbl_last = (tbl_repeat == '0) ?
    '0 : tbl_repeat - 1'b1;

  // Sequencer FSM with registered outputs.
  always_ff @(posedge clock_in) begin
    if (reset) begin
      state       <= IDLE;
      slot        <= '0;
      divide_by   <= '0;
      div_reset_n <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      rep_cnt     <= '0;
      rep_lim     <= '0;
      div_clock_q <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state != LOAD) begin
        div_clock_q <= div_clock;
      end
      if (stop) begin
        state       <= IDLE;
        div_reset_n <= 1'b0;
        busy        <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            div_reset_n <= 1'b0;
            busy        <= 1'b0;
            if (start) begin
              state <= LOAD;
              slot  <= '0;
              busy  <= 1'b1;
            end
          end
          LOAD: begin
            divide_by   <= tbl_divide;
            rep_cnt     <= '0;
            rep_lim     <= tbl_last;
            div_clock_q <= 1'b0;
            if (tbl_divide == '0) begin
              if (loop && slot != '0) begin
                state <= LOAD;
                slot  <= '0;
              end else begin
                state <= IDLE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end
            end else begin
              state       <= RUN;
              div_reset_n <= 1'b1;
            end
          end
          RUN: begin
            if (rise) begin
              if (rep_cnt == rep_lim) begin
                div_reset_n <= 1'b0;
                if (slot == LAST_SLOT && !loop) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                end else begin
                  state <= LOAD;
                  slot  <= (slot == LAST_SLOT) ?
                    '0 : slot + 1'b1;
                end
              end else begin
                rep_cnt <= rep_cnt + 1'b1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
